// File: rtl/buffer_loader.sv
// buffer_loader: write-side sequencer for the buffer_mult weight buffer.
// Loads load_len stream words into buffer addresses 0..load_len-1, waits one
// GAP cycle so the final write commits, then replays the buffer n_pass times
// by driving the read address.
// Optional feature macro: BUFFER_LOADER_ERR_EN adds a sticky err output that
// flags a start outside IDLE or a start with an illegal load_len.
//
// Handshake rule: a stream word transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is a register and does not depend on
// in_valid in the same cycle. rd_hold stalls the sweep: while it is high at a
// rising edge, rdb_addr, rd_vld and rd_last keep their values.

`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef ADDR_B
`define ADDR_B 6
`endif
`ifndef CAP_B
`define CAP_B 4
`endif

module buffer_loader #(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int ADDR_B   = `ADDR_B,
  parameter int CAP_B    = `CAP_B,
  parameter int PASS_B   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CAP_B:0]      load_len,
  input  logic [PASS_B-1:0]   n_pass,
  input  logic                in_valid,
  input  logic [DATA_WID-1:0] in_data,
  output logic                in_ready,
  output logic                wrb,
  output logic [ADDR_B-1:0]   wrb_addr,
  output logic [DATA_WID-1:0] wrb_data,
  output logic [ADDR_B-1:0]   rdb_addr,
  input  logic                rd_hold,
  output logic                rd_vld,
  output logic                rd_last,
  output logic                busy,
  output logic                done,
`ifdef BUFFER_LOADER_ERR_EN
  output logic                err,
`endif
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP, S_SWEEP} state_t;

  localparam logic [CAP_B:0]    MAX_LEN = (CAP_B+1)'(1) << CAP_B;
  localparam logic [CAP_B:0]    LEN_ONE = (CAP_B+1)'(1);
  localparam logic [PASS_B-1:0] NP_ONE  = PASS_B'(1);

  state_t              state;
  logic [CAP_B:0]      len_q;
  logic [PASS_B-1:0]   np_q;
  logic [CAP_B-1:0]    wr_cnt;
  logic [CAP_B-1:0]    rd_cnt;
  logic [PASS_B-1:0]   pass_cnt;

  logic                start_ok;
  logic                last_wr;
  logic                last_addr;
  logic                last_pass;
  logic [CAP_B-1:0]    rd_nxt;
  logic [PASS_B-1:0]   pass_nxt;
  logic                rd_last_nxt;
  logic                first_last;

  assign state_dbg = state;

  // Decode counter end conditions and the next sweep position.
  always_comb begin
    start_ok    = (load_len != '0) && (load_len <= MAX_LEN);
    last_wr     = ({1'b0, wr_cnt} == (len_q - LEN_ONE));
    last_addr   = ({1'b0, rd_cnt} == (len_q - LEN_ONE));
    last_pass   = (pass_cnt == (np_q - NP_ONE));
    rd_nxt      = rd_cnt + 1'b1;
    pass_nxt    = pass_cnt;
    if (last_addr) begin
      rd_nxt   = '0;
      pass_nxt = pass_cnt + 1'b1;
    end
    rd_last_nxt = ({1'b0, rd_nxt} == (len_q - LEN_ONE)) && (pass_nxt == (np_q - NP_ONE));
    first_last  = (len_q == LEN_ONE) && (np_q == NP_ONE);
  end

  // Job sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      np_q     <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      pass_cnt <= '0;
      in_ready <= 1'b0;
      wrb      <= 1'b0;
      wrb_addr <= '0;
      wrb_data <= '0;
      rdb_addr <= '0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef BUFFER_LOADER_ERR_EN
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      wrb  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && start_ok) begin
            len_q    <= load_len;
            np_q     <= n_pass;
            wr_cnt   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready) begin
            wrb      <= 1'b1;
            wrb_addr <= ADDR_B'(wr_cnt);
            wrb_data <= in_data;
            wr_cnt   <= wr_cnt + 1'b1;
            if (last_wr) begin
              in_ready <= 1'b0;
              state    <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (np_q == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            rd_cnt   <= '0;
            pass_cnt <= '0;
            rdb_addr <= '0;
            rd_vld   <= 1'b1;
            rd_last  <= first_last;
            state    <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (!rd_hold) begin
            if (last_addr && last_pass) begin
              rd_vld  <= 1'b0;
              rd_last <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              rd_cnt   <= rd_nxt;
              pass_cnt <= pass_nxt;
              rdb_addr <= ADDR_B'(rd_nxt);
              rd_last  <= rd_last_nxt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef BUFFER_LOADER_ERR_EN
      if (start && ((state != S_IDLE) || !start_ok)) begin
        err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_buffer_loader.sv
// Testbench for buffer_loader: scoreboard of expected buffer writes and
// expected sweep addresses, plus latency, stall, boundary and reset checks.

module tb_buffer_loader;

  localparam int DATA_WID = 16;
  localparam int ADDR_B   = 6;
  localparam int CAP_B    = 4;
  localparam int PASS_B   = 8;

  logic                clk;
  logic                reset;
  logic                start;
  logic [CAP_B:0]      load_len;
  logic [PASS_B-1:0]   n_pass;
  logic                in_valid;
  logic [DATA_WID-1:0] in_data;
  logic                in_ready;
  logic                wrb;
  logic [ADDR_B-1:0]   wrb_addr;
  logic [DATA_WID-1:0] wrb_data;
  logic [ADDR_B-1:0]   rdb_addr;
  logic                rd_hold;
  logic                rd_vld;
  logic                rd_last;
  logic                busy;
  logic                done;
`ifdef BUFFER_LOADER_ERR_EN
  logic                err;
`endif
  logic [1:0]          state_dbg;

  buffer_loader #(
    .DATA_WID(DATA_WID), .ADDR_B(ADDR_B), .CAP_B(CAP_B), .PASS_B(PASS_B)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len), .n_pass(n_pass),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wrb(wrb), .wrb_addr(wrb_addr), .wrb_data(wrb_data), .rdb_addr(rdb_addr),
    .rd_hold(rd_hold), .rd_vld(rd_vld), .rd_last(rd_last), .busy(busy), .done(done),
`ifdef BUFFER_LOADER_ERR_EN
    .err(err),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [ADDR_B+DATA_WID-1:0] exp_wr_q[$];
  logic [ADDR_B:0]            exp_rd_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wr_seen = 0;
  int rv_cnt = 0;
  int stall_seen = 0;
  int hs_cyc = 0;
  logic hold_en = 1'b0;
  logic [ADDR_B-1:0]   last_wa = '0;
  logic [DATA_WID-1:0] last_wd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [ADDR_B+DATA_WID-1:0] ew;
    logic [ADDR_B:0]            er;
    if (!reset) begin
      last_wa = '0;
      last_wd = '0;
    end else begin
      if (wrb) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(wrb_addr), 64'hffff);
        else begin
          ew = exp_wr_q.pop_front();
          check("wr_addr", 64'(wrb_addr), 64'(ew[ADDR_B+DATA_WID-1:DATA_WID]));
          check("wr_data", 64'(wrb_data), 64'(ew[DATA_WID-1:0]));
        end
        last_wa = wrb_addr;
        last_wd = wrb_data;
      end else if (hold_en) begin
        check("wr_addr_hold", 64'(wrb_addr), 64'(last_wa));
        check("wr_data_hold", 64'(wrb_data), 64'(last_wd));
      end
      if (rd_vld) begin
        rv_cnt++;
        if (rdb_addr == ADDR_B'(2)) stall_seen++;
        if (!rd_hold) begin
          if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(rdb_addr), 64'hffff);
          else begin
            er = exp_rd_q.pop_front();
            check("rd_addr_last", {63'(rdb_addr), rd_last}, {63'(er[ADDR_B-1:0]), er[ADDR_B]});
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", 64'(busy), 64'd0);
        check("done_rd_vld", 64'(rd_vld), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input int len, input int np);
    bit legal;
    legal = (len >= 1) && (len <= (1 << CAP_B));
    @(posedge clk); #1;
    start = 1'b1;
    load_len = (CAP_B+1)'(len);
    n_pass = PASS_B'(np);
    @(posedge clk); #1;
    start = 1'b0;
    if (legal) begin
      for (int p = 0; p < np; p++)
        for (int a = 0; a < len; a++)
          exp_rd_q.push_back({((p == np - 1) && (a == len - 1)), ADDR_B'(a)});
    end
    @(negedge clk);
    check("start_busy", 64'(busy), 64'(legal));
    check("start_in_ready", 64'(in_ready), 64'(legal));
  endtask

  // mode 0: back-to-back 0x11*(i+1); mode 1: random gaps/data; mode 2: valid 1,0,0,1,1
  task automatic send_stream(input int len, input int mode);
    int idle;
    logic [DATA_WID-1:0] d;
    for (int i = 0; i < len; i++) begin
      idle = 0;
      if (mode == 1) idle = $urandom_range(0, 2);
      if (mode == 2 && i == 1) idle = 2;
      for (int k = 0; k < idle; k++) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = DATA_WID'($urandom);
      end
      d = (mode == 0) ? DATA_WID'(16'h11 * (i + 1)) : DATA_WID'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = d;
      exp_wr_q.push_back({ADDR_B'(i), d});
      @(negedge clk);
      check("in_ready_hs", 64'(in_ready), 64'd1);
      hs_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rd_addr(input int a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_vld && rdb_addr == ADDR_B'(a)) && n < 200);
    if (n >= 200) check("rd_addr_timeout", 64'(rdb_addr), 64'(a));
  endtask

  task automatic run_job(input int len, input int np, input int mode, input string tag);
    int d0;
    d0 = done_cnt;
    start_job(len, np);
    send_stream(len, mode);
    wait_done(500);
    check({tag, "_latency"}, 64'(done_cyc - hs_cyc), 64'(2 + len * np));
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, r0, w0;
    reset = 1'b0; start = 1'b0; load_len = '0; n_pass = '0;
    in_valid = 1'b0; in_data = '0; rd_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {58'(0), in_ready, wrb, rd_vld, rd_last, busy, done}, 64'd0);
    check("rst_addrs", {16'(wrb_addr), 32'(wrb_data), 16'(rdb_addr)}, 64'd0);
`ifdef BUFFER_LOADER_ERR_EN
    check("rst_err", 64'(err), 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;

    // basic load and sweep
    run_job(4, 2, 0, "basic");

    // stream gaps with hold of write port
    w0 = wr_seen;
    hold_en = 1'b1;
    start_job(3, 1);
    send_stream(3, 2);
    wait_done(200);
    hold_en = 1'b0;
    check("gap_wr_count", 64'(wr_seen - w0), 64'd3);

    // sweep stall at address 2
    start_job(4, 1);
    send_stream(4, 0);
    stall_seen = 0;
    wait_rd_addr(1);
    @(posedge clk); #1;
    rd_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd_hold = 1'b0;
    wait_done(200);
    check("stall_cycles_at_2", 64'(stall_seen), 64'd4);
    check("stall_latency", 64'(done_cyc - hs_cyc), 64'd9);

    // boundaries: full depth, single pass; zero passes
    run_job(16, 1, 1, "full_depth");
    r0 = rv_cnt;
    run_job(3, 0, 1, "zero_pass");
    check("zero_pass_no_rd", 64'(rv_cnt - r0), 64'd0);

    // illegal starts are ignored
    start_job(0, 1);
    start_job(17, 1);
`ifdef BUFFER_LOADER_ERR_EN
    check("err_illegal", 64'(err), 64'd1);
`endif

    // reset mid-sweep
    start_job(8, 2);
    send_stream(8, 1);
    wait_rd_addr(3);
    d0 = done_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_outputs", {58'(0), in_ready, wrb, rd_vld, rd_last, busy, done}, 64'd0);
    check("midrst_addrs", {16'(wrb_addr), 32'(wrb_data), 16'(rdb_addr)}, 64'd0);
    exp_rd_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
`ifdef BUFFER_LOADER_ERR_EN
    check("midrst_err_clr", 64'(err), 64'd0);
`endif
    run_job(5, 3, 1, "after_rst");

    // start while busy: ignored (job keeps its own length and passes)
    start_job(6, 2);
    @(posedge clk); #1;
    start = 1'b1;
    load_len = (CAP_B+1)'(2);
    n_pass = PASS_B'(5);
    @(posedge clk); #1;
    start = 1'b0;
    send_stream(6, 1);
    wait_done(300);
    check("busy_start_latency", 64'(done_cyc - hs_cyc), 64'd14);
`ifdef BUFFER_LOADER_ERR_EN
    check("err_busy_start", 64'(err), 64'd1);
`endif

    // a few random legal jobs
    for (int j = 0; j < 3; j++) run_job($urandom_range(1, 16), $urandom_range(1, 3), 1, "rand");

    repeat (3) @(posedge clk);
    check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/buffer_loader.md
# buffer_loader

Write-side sequencer for the single-port weight buffer in the `buffer_mult` datapath. It accepts a valid/ready stream of `DATA_WID`-bit words and writes them to consecutive buffer addresses starting at 0. It then replays the buffer by driving the read address, making a programmable number of full passes for the downstream multiplier. It drives the write ports and the read address of the existing buffer.

## Interface
- `DATA_WID`, default `` `CNN_XLEN ``: width of stream words and buffer data.
- `ADDR_B`, default `` `ADDR_B ``: buffer address width.
- `CAP_B`, default `` `CAP_B ``: log2 of usable buffer depth; `CAP_B <= ADDR_B`.
- `PASS_B`, default 8: width of the pass-count field.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle job launch; sampled only in IDLE.
- `load_len`  in  CAP_B+1  number of words to load, valid range 1..2**CAP_B; sampled with `start`.
- `n_pass`  in  PASS_B  number of read sweeps; sampled with `start`.
- `in_valid`  in  1  stream word present.
- `in_data`  in  DATA_WID  stream word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `wrb`  out  1  buffer write strobe.
- `wrb_addr`  out  ADDR_B  buffer write address.
- `wrb_data`  out  DATA_WID  buffer write data.
- `rdb_addr`  out  ADDR_B  buffer read address.
- `rd_hold`  in  1  downstream stall; freezes the sweep.
- `rd_vld`  out  1  `rdb_addr` is a live sweep address.
- `rd_last`  out  1  final address of the final pass.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Four states: IDLE, LOAD, GAP, SWEEP.
- **IDLE**
  - `start` with `load_len` in 1..2**CAP_B: latch `load_len` and `n_pass`, clear the write counter, go to LOAD.
  - `start` with `load_len` of 0 or greater than 2**CAP_B: ignored.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid & in_ready`) registers `wrb`=1, `wrb_data`=`in_data`, `wrb_addr`=write counter. The counter then increments.
  - No handshake: `wrb`=0 next cycle; `wrb_addr` and `wrb_data` hold.
  - On the handshake of word `load_len-1`, `in_ready` drops the next cycle and the state goes to GAP.
- **GAP**
  - One cycle, so the last write commits before the first read.
  - `n_pass`==0: go to IDLE and pulse `done`.
  - Otherwise: go to SWEEP with the read counter at 0 and the pass counter at 0.
- **SWEEP**
  - `rd_vld`=1; `rdb_addr` equals the read counter.
  - Each cycle with `rd_hold`=0, the address advances. After `load_len-1` it wraps to 0 and the pass counter increments.
  - `rd_hold`=1 freezes `rdb_addr`, `rd_vld` and `rd_last`.
  - `rd_last`=1 while `rdb_addr`==`load_len-1` and the pass counter equals `n_pass-1`.
  - When that address advances, go to IDLE: `rd_vld`=0, `rd_last`=0, `done`=1 for one cycle.
- `start` outside IDLE is ignored. The latched `load_len` and `n_pass` never change mid-job.
- All outputs are registered. Upper bits of `wrb_addr` and `rdb_addr` above CAP_B are 0.

## Timing
- Reset values: `in_ready`, `wrb`, `rd_vld`, `rd_last`, `busy` and `done` are 0; `wrb_addr`, `wrb_data` and `rdb_addr` are all-zero.
- Asserting `reset` mid-job aborts immediately to IDLE with the outputs above. No partial `done` is produced.
- `start` at edge N: `busy` and `in_ready` are 1 after edge N+1.
- Handshake at edge M: `wrb`, `wrb_addr` and `wrb_data` are valid after edge M+1, for exactly one cycle.
- Last handshake at edge L:
  - last write strobe after L+1;
  - GAP during L+1..L+2;
  - first `rd_vld` with `rdb_addr`=0 after L+2.
- Unstalled job length from the last handshake to `done`: 2 + `load_len`·`n_pass` cycles.
- `done` and `busy`=0 appear in the same cycle; a new `start` is accepted in that cycle.

## Configuration
- `BUFFER_LOADER_ERR_EN` defined:
  - adds output `err` (1 bit, reset 0);
  - `err` is sticky-set by a `start` outside IDLE, or by a `start` with an illegal `load_len`;
  - `err` is cleared only by `reset`.
- Not defined: no `err` port; illegal starts are silently ignored.

## Test plan
- Basic load and sweep: `load_len`=4, `n_pass`=2, words 0x11..0x44 streamed back-to-back.
  - Writes go to addr 0..3 on consecutive cycles.
  - `rdb_addr` then runs 0,1,2,3,0,1,2,3.
  - `rd_last` is high only on the second 3; `done` pulses once.
- Stream gaps: `in_valid` toggled 1,0,0,1,1 with `load_len`=3.
  - `wrb` is high on exactly 3 cycles, with `wrb_addr` 0, 1, 2 in order.
  - `wrb_addr` and `wrb_data` hold between writes.
- Sweep stall: `rd_hold`=1 for 3 cycles at `rdb_addr`=2.
  - Address stays 2 with `rd_vld`=1 for 4 cycles, then resumes at 3.
- Boundaries:
  - `load_len`=2**CAP_B with `n_pass`=1: addresses wrap to the full depth; one sweep.
  - `n_pass`=0: `done` is high 2 cycles after the last handshake, with `rd_vld` never high.
- Reset and illegal starts:
  - `reset` low mid-SWEEP: all outputs are 0 in the same cycle, no `done` is produced, and a subsequent job completes normally.
  - `start` while busy: ignored, and `err`=1 when `BUFFER_LOADER_ERR_EN` is defined.
